// File: rtl/dual_port_ram_be.sv
// True dual-port RAM with byte enables, per-port read-during-write mode and a dual-write collision counter.
// Read latency is 1 cycle with OUT_REG=0 and 2 cycles with OUT_REG=1; the read valid strobe follows the data.
// There is no backpressure: each port accepts one read and one write every cycle without stalling.
module dual_port_ram_be #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int BYTE_WIDTH = 8,
    parameter int RDW_MODE   = 0,
    parameter int OUT_REG    = 0,
    parameter int CNT_WIDTH  = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic [ADDR_WIDTH-1:0]            addr_a,
    input  logic [DATA_WIDTH-1:0]            data_a,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_a,
    input  logic                             we_a,
    input  logic                             re_a,
    output logic [DATA_WIDTH-1:0]            q_a,
    output logic                             q_a_valid,
    input  logic [ADDR_WIDTH-1:0]            addr_b,
    input  logic [DATA_WIDTH-1:0]            data_b,
    input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_b,
    input  logic                             we_b,
    input  logic                             re_b,
    output logic [DATA_WIDTH-1:0]            q_b,
    output logic                             q_b_valid,
    output logic                             coll,
    output logic [CNT_WIDTH-1:0]             coll_cnt
);
    localparam int NBE   = DATA_WIDTH / BYTE_WIDTH;
    localparam int DEPTH = 1 << ADDR_WIDTH;
    localparam bit WRITE_FIRST = (RDW_MODE != 0);

    logic [DATA_WIDTH-1:0] mem [DEPTH] = '{default: '0};

    logic                  same_addr;
    logic                  coll_now;
    logic [DATA_WIDTH-1:0] old_a, old_b;
    logic [DATA_WIDTH-1:0] fin_a, fin_b;
    logic [DATA_WIDTH-1:0] rd_a_dat, rd_b_dat;

    assign same_addr = (addr_a == addr_b);
    assign coll_now  = same_addr && we_a && we_b;

    // Final word per address: port A lanes win, port B fills lanes A leaves untouched
    // when both target the same word, remaining lanes keep the old contents.
    always_comb begin
        old_a = mem[addr_a];
        old_b = mem[addr_b];
        fin_a = old_a;
        fin_b = old_b;
        for (int i = 0; i < NBE; i++) begin
            if (we_a && be_a[i])
                fin_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_a[i*BYTE_WIDTH +: BYTE_WIDTH];
            else if (same_addr && we_b && be_b[i])
                fin_a[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
            if (we_b && be_b[i])
                fin_b[i*BYTE_WIDTH +: BYTE_WIDTH] = data_b[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
        if (same_addr)
            fin_b = fin_a;
    end

    // Cross-port readers always see old_x; only a port's own write can forward.
    assign rd_a_dat = (WRITE_FIRST && we_a) ? fin_a : old_a;
    assign rd_b_dat = (WRITE_FIRST && we_b) ? fin_b : old_b;

    always_ff @(posedge clk) begin
        if (we_a)
            mem[addr_a] <= fin_a;
        if (we_b)
            mem[addr_b] <= fin_b;
    end

    logic [DATA_WIDTH-1:0] s1_a_dat, s1_b_dat;
    logic                  s1_a_vld, s1_b_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_a_dat <= '0;
            s1_b_dat <= '0;
            s1_a_vld <= 1'b0;
            s1_b_vld <= 1'b0;
        end else begin
            s1_a_vld <= re_a;
            s1_b_vld <= re_b;
            if (re_a)
                s1_a_dat <= rd_a_dat;
            if (re_b)
                s1_b_dat <= rd_b_dat;
        end
    end

    generate
        if (OUT_REG != 0) begin : g_out_reg
            logic [DATA_WIDTH-1:0] s2_a_dat, s2_b_dat;
            logic                  s2_a_vld, s2_b_vld;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    s2_a_dat <= '0;
                    s2_b_dat <= '0;
                    s2_a_vld <= 1'b0;
                    s2_b_vld <= 1'b0;
                end else begin
                    s2_a_vld <= s1_a_vld;
                    s2_b_vld <= s1_b_vld;
                    if (s1_a_vld)
                        s2_a_dat <= s1_a_dat;
                    if (s1_b_vld)
                        s2_b_dat <= s1_b_dat;
                end
            end

            assign q_a       = s2_a_dat;
            assign q_b       = s2_b_dat;
            assign q_a_valid = s2_a_vld;
            assign q_b_valid = s2_b_vld;
        end else begin : g_no_out_reg
            assign q_a       = s1_a_dat;
            assign q_b       = s1_b_dat;
            assign q_a_valid = s1_a_vld;
            assign q_b_valid = s1_b_vld;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            coll     <= 1'b0;
            coll_cnt <= '0;
        end else if (coll_now) begin
            coll <= 1'b1;
            if (coll_cnt != {CNT_WIDTH{1'b1}})
                coll_cnt <= coll_cnt + CNT_WIDTH'(1);
        end
    end

endmodule
